// File: rtl/mem_stage_pkg.sv
// Shared types, constants and helpers for the RV32I memory-access stage.
package mem_stage_pkg;

    localparam int XLEN              = 32;
    localparam int ADDR_WIDTH        = 5;
    localparam int MEM_DEPTH_DEFAULT = 1024;

    // Load funct3 encodings
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;

    // Store funct3 encodings
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Write-back source; WB_NONE is the all-zero encoding so a cleared slot drives 0.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC4  = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic [XLEN-1:0]       alu;
        logic [XLEN-1:0]       pc4;
        logic [ADDR_WIDTH-1:0] rd;
        logic [2:0]            funct3;
        logic [1:0]            offset;
        wb_sel_e               wb_sel;
        logic                  valid;
        logic                  reg_write;
        logic                  fault;
    } memwb_t;

    localparam memwb_t MEMWB_RESET = '{
        alu:       '0,
        pc4:       '0,
        rd:        '0,
        funct3:    '0,
        offset:    '0,
        wb_sel:    WB_NONE,
        valid:     1'b0,
        reg_write: 1'b0,
        fault:     1'b0
    };

    // Access size from the low funct3 bits; 2'b11 is illegal and is flagged separately.
    function automatic mem_size_e mem_size(input logic [1:0] funct3_lo);
        case (funct3_lo)
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            default: return MEM_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input mem_size_e size, input logic [1:0] offset);
        case (size)
            MEM_BYTE: return 1'b1;
            MEM_HALF: return !offset[0];
            default:  return offset == 2'b00;
        endcase
    endfunction

    // Select the addressed byte/half of a RAM word and extend it to XLEN.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                     input logic [1:0]      offset,
                                                     input logic [2:0]      funct3);
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] result;
        shifted = word >> {offset, 3'b000};
        case (funct3)
            FUNCT3_LB:             result = {{24{shifted[7]}}, shifted[7:0]};
            FUNCT3_LH:             result = {{16{shifted[15]}}, shifted[15:0]};
            FUNCT3_LBU:            result = {24'b0, shifted[7:0]};
            FUNCT3_LHU:            result = {16'b0, shifted[15:0]};
            FUNCT3_LW, FUNCT3_LWU: result = word;
            default:               result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Data memory: single-port synchronous RAM, byte-lane writes, registered read.
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = XLEN
) (
    input  logic            clk,
    input  logic            re_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_array [DEPTH];
    logic [DW-1:0] rdata_q;

    // Lane-masked write and enabled registered read (read-before-write on the same address).
    // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
    // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < DW/8; lane++) begin
            if (be_i[lane]) begin
                mem_array[addr_i][lane*8 +: 8] <= wdata_i[lane*8 +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_array[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: alignment/lane logic, data memory, MEM/WB register and write-back mux.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = XLEN,
    parameter int DATA_MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  ex_valid_i,
    input  logic [DATA_WIDTH-1:0] ex_alu_result_i,
    input  logic [DATA_WIDTH-1:0] ex_store_data_i,
    input  logic [DATA_WIDTH-1:0] ex_pc4_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_mem_write_i,
    input  logic                  ex_reg_write_i,
    input  logic [ADDR_WIDTH-1:0] ex_rd_i,
    input  wb_sel_e               ex_wb_sel_i,
    output logic [DATA_WIDTH-1:0] mem_fw_data_o,
    output logic                  wb_valid_o,
    output logic                  wb_reg_write_o,
    output logic [ADDR_WIDTH-1:0] wb_rd_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  wb_fault_o
);

    localparam int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH);

    logic [1:0]                     offset;
    logic [DATA_MEM_ADDR_WIDTH-1:0] word_idx;
    mem_size_e                      size;
    logic                           load_legal;
    logic                           store_legal;
    logic                           aligned;
    logic                           access_fault;
    logic                           store_fire;
    logic [3:0]                     byte_en;
    logic [DATA_WIDTH-1:0]          wdata;
    logic [DATA_WIDTH-1:0]          rdata;
    memwb_t                         memwb_d;
    memwb_t                         memwb_q;

    // Decode address, access size and legality of the instruction in EX/MEM.
    always_comb begin
        offset       = ex_alu_result_i[1:0];
        word_idx     = ex_alu_result_i[DATA_MEM_ADDR_WIDTH+1:2];
        size         = mem_size(ex_funct3_i[1:0]);
        load_legal   = ex_funct3_i[1:0] != 2'b11;
        store_legal  = !ex_funct3_i[2] && (ex_funct3_i[1:0] != 2'b11);
        aligned      = is_aligned(size, offset);
        access_fault = ex_valid_i &&
                       ((ex_mem_read_i  && !(load_legal  && aligned)) ||
                        (ex_mem_write_i && !(store_legal && aligned)));
        // Reset wins over everything, so a store in the reset cycle never lands.
        store_fire   = ex_valid_i && ex_mem_write_i && !stall_i && !rst && !access_fault;
    end

    // Byte-lane enables and replicated store data.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        byte_en = 4'b0000;
        wdata   = ex_store_data_i;
        case (size)
            MEM_BYTE: wdata = {4{ex_store_data_i[7:0]}};
            MEM_HALF: wdata = {2{ex_store_data_i[15:0]}};
            default:  wdata = ex_store_data_i;
        endcase
        if (store_fire) begin
            case (size)
                MEM_BYTE: byte_en = 4'b0001 << offset;
                MEM_HALF: byte_en = 4'b0011 << offset;
                default:  byte_en = 4'b1111;
            endcase
        end
    end

    data_mem #(
        .DEPTH (DATA_MEM_DEPTH),
        .AW    (DATA_MEM_ADDR_WIDTH),
        .DW    (DATA_WIDTH)
    ) u_data_mem (
        .clk     (clk),
        .re_i    (!stall_i),
        .be_i    (byte_en),
        .addr_i  (word_idx),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    // Next MEM/WB contents: hold on stall, otherwise capture the EX/MEM slot.
    always_comb begin
        memwb_d = memwb_q;
        if (!stall_i) begin
            memwb_d.valid     = ex_valid_i;
            memwb_d.reg_write = ex_valid_i && ex_reg_write_i && !access_fault;
            memwb_d.fault     = access_fault;
            memwb_d.rd        = ex_rd_i;
            memwb_d.wb_sel    = ex_wb_sel_i;
            memwb_d.alu       = ex_alu_result_i;
            memwb_d.pc4       = ex_pc4_i;
            memwb_d.funct3    = ex_funct3_i;
            memwb_d.offset    = offset;
        end
    end

    // MEM/WB register with synchronous reset taking priority over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_q <= MEMWB_RESET;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    // Write-back value selection; a faulting load returns zero.
    always_comb begin
        wb_data_o = '0;
        case (memwb_q.wb_sel)
            WB_ALU:  wb_data_o = memwb_q.alu;
            WB_MEM:  wb_data_o = memwb_q.fault ? '0
                               : load_extend(rdata, memwb_q.offset, memwb_q.funct3);
            WB_PC4:  wb_data_o = memwb_q.pc4;
            default: wb_data_o = '0;
        endcase
    end

    assign mem_fw_data_o  = ex_alu_result_i;
    assign wb_valid_o     = memwb_q.valid;
    assign wb_reg_write_o = memwb_q.reg_write;
    assign wb_rd_o        = memwb_q.rd;
    assign wb_fault_o     = memwb_q.fault;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, a hand-written stall
// sequence, and randomized traffic against a byte-array memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        ex_valid_i;
    logic [31:0] ex_alu_result_i;
    logic [31:0] ex_store_data_i;
    logic [31:0] ex_pc4_i;
    logic [2:0]  ex_funct3_i;
    logic        ex_mem_read_i;
    logic        ex_mem_write_i;
    logic        ex_reg_write_i;
    logic [4:0]  ex_rd_i;
    wb_sel_e     ex_wb_sel_i;
    logic [31:0] mem_fw_data_o;
    logic        wb_valid_o;
    logic        wb_reg_write_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_fault_o;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .ex_valid_i      (ex_valid_i),
        .ex_alu_result_i (ex_alu_result_i),
        .ex_store_data_i (ex_store_data_i),
        .ex_pc4_i        (ex_pc4_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_mem_read_i   (ex_mem_read_i),
        .ex_mem_write_i  (ex_mem_write_i),
        .ex_reg_write_i  (ex_reg_write_i),
        .ex_rd_i         (ex_rd_i),
        .ex_wb_sel_i     (ex_wb_sel_i),
        .mem_fw_data_o   (mem_fw_data_o),
        .wb_valid_o      (wb_valid_o),
        .wb_reg_write_o  (wb_reg_write_o),
        .wb_rd_o         (wb_rd_o),
        .wb_data_o       (wb_data_o),
        .wb_fault_o      (wb_fault_o)
    );

    typedef struct {
        bit          rst, stall, valid, mr, mw, rw;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, pc4;
        logic [4:0]  rd;
        wb_sel_e     sel;
        bit          e_valid, e_rw, e_fault;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        bit          chk;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem [4096];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{rst: 0, stall: 0, valid: 0, mr: 0, mw: 0, rw: 0, f3: 3'b000,
              addr: 32'h0, sdata: 32'h0, pc4: 32'h0, rd: 5'd0, sel: WB_NONE,
              e_valid: 0, e_rw: 0, e_fault: 0, e_rd: 5'd0, e_data: 32'h0, chk: 1};
        return v;
    endfunction

    function automatic vec_t ld(input logic [2:0] f3, input logic [31:0] addr,
                                input logic [4:0] rd, input logic [31:0] e_data, input bit e_fault);
        vec_t v;
        v = idle();
        v.valid = 1; v.mr = 1; v.rw = 1; v.f3 = f3; v.addr = addr; v.rd = rd; v.sel = WB_MEM;
        v.e_valid = 1; v.e_rw = !e_fault; v.e_fault = e_fault; v.e_rd = rd; v.e_data = e_data;
        return v;
    endfunction

    function automatic vec_t st(input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sdata, input bit rw, input bit e_fault);
        vec_t v;
        v = idle();
        v.valid = 1; v.mw = 1; v.rw = rw; v.f3 = f3; v.addr = addr; v.sdata = sdata;
        v.e_valid = 1; v.e_rw = rw && !e_fault; v.e_fault = e_fault;
        return v;
    endfunction

    function automatic vec_t with_exp(input vec_t inp, input vec_t e);
        vec_t v;
        v = inp;
        v.e_valid = e.e_valid; v.e_rw = e.e_rw; v.e_fault = e.e_fault;
        v.e_rd = e.e_rd; v.e_data = e.e_data; v.chk = e.chk;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst             = v.rst;
        stall_i         = v.stall;
        ex_valid_i      = v.valid;
        ex_mem_read_i   = v.mr;
        ex_mem_write_i  = v.mw;
        ex_reg_write_i  = v.rw;
        ex_funct3_i     = v.f3;
        ex_alu_result_i = v.addr;
        ex_store_data_i = v.sdata;
        ex_pc4_i        = v.pc4;
        ex_rd_i         = v.rd;
        ex_wb_sel_i     = v.sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input vec_t v);
        check({tag, ".valid"}, 32'(wb_valid_o), 32'(v.e_valid));
        check({tag, ".reg_write"}, 32'(wb_reg_write_o), 32'(v.e_rw));
        check({tag, ".fault"}, 32'(wb_fault_o), 32'(v.e_fault));
        check({tag, ".fw"}, mem_fw_data_o, v.addr);
        if (v.chk) begin
            check({tag, ".rd"}, 32'(wb_rd_o), 32'(v.e_rd));
            check({tag, ".data"}, wb_data_o, v.e_data);
        end
    endtask

    // Reference load: assemble bytes from the model and extend by access type.
    function automatic logic [31:0] model_load(input logic [11:0] a, input logic [2:0] f3);
        logic [31:0] w;
        int n;
        w = 32'h0;
        n = 1 << f3[1:0];
        for (int k = 0; k < n; k++) begin
            w = w | (32'(ref_mem[12'(a + k)]) << (8 * k));
        end
        if (!f3[2] && n < 4 && w[8*n-1]) begin
            w = w | (32'hFFFF_FFFF << (8 * n));
        end
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        vec_t l;
        vec_t e;

        drive(idle());

        // ---------------- directed table ----------------
        v = idle(); v.rst = 1; tbl.push_back(v);
        tbl.push_back(st(FUNCT3_SW, 32'h100, 32'hDEADBEEF, 0, 0));
        tbl.push_back(ld(FUNCT3_LW, 32'h100, 5'd5, 32'hDEADBEEF, 0));
        tbl.push_back(st(FUNCT3_SW, 32'h200, 32'h0, 0, 0));
        tbl.push_back(st(FUNCT3_SB, 32'h203, 32'h12345680, 0, 0));
        tbl.push_back(ld(FUNCT3_LB,  32'h203, 5'd6, 32'hFFFFFF80, 0));
        tbl.push_back(ld(FUNCT3_LBU, 32'h203, 5'd7, 32'h00000080, 0));
        tbl.push_back(ld(FUNCT3_LW,  32'h200, 5'd8, 32'h80000000, 0));
        tbl.push_back(st(FUNCT3_SH, 32'h101, 32'h0000BEEF, 1, 1));
        tbl.push_back(ld(FUNCT3_LW,  32'h100, 5'd9,  32'hDEADBEEF, 0));
        tbl.push_back(ld(FUNCT3_LW,  32'h102, 5'd10, 32'h0, 1));
        tbl.push_back(ld(FUNCT3_LH,  32'h102, 5'd11, 32'hFFFFDEAD, 0));
        tbl.push_back(ld(FUNCT3_LHU, 32'h100, 5'd12, 32'h0000BEEF, 0));
        tbl.push_back(ld(3'b011, 32'h100, 5'd13, 32'h0, 1));
        tbl.push_back(ld(3'b111, 32'h100, 5'd13, 32'h0, 1));
        tbl.push_back(st(3'b100, 32'h100, 32'h0, 0, 1));
        tbl.push_back(ld(FUNCT3_LW,  32'h100, 5'd14, 32'hDEADBEEF, 0));
        tbl.push_back(st(FUNCT3_SW, 32'h104, 32'h0, 0, 0));
        l = ld(FUNCT3_LW, 32'h100, 5'd15, 32'hDEADBEEF, 0);
        tbl.push_back(l);
        for (int s = 0; s < 3; s++) begin
            v = st(FUNCT3_SW, 32'h104, 32'h22222222, 0, 0);
            v.stall = 1;
            tbl.push_back(with_exp(v, l));
        end
        tbl.push_back(ld(FUNCT3_LW, 32'h104, 5'd16, 32'h0, 0));
        tbl.push_back(st(FUNCT3_SW, 32'h104, 32'h22222222, 0, 0));
        v = st(FUNCT3_SW, 32'h104, 32'h33333333, 0, 0); v.rst = 1;
        tbl.push_back(with_exp(v, idle()));
        tbl.push_back(ld(FUNCT3_LW, 32'h104, 5'd17, 32'h22222222, 0));
        tbl.push_back(ld(FUNCT3_LW, 32'h100, 5'd18, 32'hDEADBEEF, 0));
        v = idle(); v.rst = 1; v.stall = 1; tbl.push_back(v);
        tbl.push_back(st(FUNCT3_SW, 32'h1004, 32'h12345678, 0, 0));
        tbl.push_back(ld(FUNCT3_LW, 32'h0004, 5'd19, 32'h12345678, 0));
        v = idle(); v.valid = 1; v.rw = 1; v.rd = 5'd1; v.sel = WB_PC4;
        v.pc4 = 32'h00000ABC; v.addr = 32'h00001234;
        v.e_valid = 1; v.e_rw = 1; v.e_rd = 5'd1; v.e_data = 32'h00000ABC;
        tbl.push_back(v);
        v = idle(); v.valid = 1; v.rw = 1; v.rd = 5'd2; v.sel = WB_ALU; v.addr = 32'hA5A5A5A5;
        v.e_valid = 1; v.e_rw = 1; v.e_rd = 5'd2; v.e_data = 32'hA5A5A5A5;
        tbl.push_back(v);
        v = st(FUNCT3_SW, 32'h104, 32'h44444444, 1, 0);
        v.valid = 0; v.sel = WB_ALU; v.e_valid = 0; v.e_rw = 0; v.chk = 0;
        tbl.push_back(v);
        tbl.push_back(ld(FUNCT3_LW,  32'h104, 5'd20, 32'h22222222, 0));
        tbl.push_back(st(FUNCT3_SH, 32'h106, 32'h0000ABCD, 0, 0));
        tbl.push_back(ld(FUNCT3_LW,  32'h104, 5'd21, 32'hABCD2222, 0));
        tbl.push_back(ld(FUNCT3_LWU, 32'h104, 5'd22, 32'hABCD2222, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            tick();
            check_wb($sformatf("vec%0d", i), tbl[i]);
        end

        // ---------------- hand sequence: byte store held off by stall ----------------
        drive(st(FUNCT3_SW, 32'h108, 32'h5A5A5A5A, 0, 0));
        tick();
        l = ld(FUNCT3_LW, 32'h108, 5'd23, 32'h5A5A5A5A, 0);
        drive(l);
        tick();
        check_wb("seq_ld", l);
        for (int s = 0; s < 2; s++) begin
            v = st(FUNCT3_SB, 32'h108, 32'h000000FF, 0, 0);
            v.stall = 1;
            v = with_exp(v, l);
            drive(v);
            tick();
            check_wb($sformatf("seq_stall%0d", s), v);
        end
        v = ld(FUNCT3_LBU, 32'h108, 5'd24, 32'h0000005A, 0);
        drive(v);
        tick();
        check_wb("seq_after", v);

        // ---------------- randomized traffic against byte-array model ----------------
        for (int w = 0; w < 16; w++) begin
            logic [31:0] val;
            val = $urandom();
            drive(st(FUNCT3_SW, 32'h300 + 32'(4 * w), val, 0, 0));
            tick();
            for (int k = 0; k < 4; k++) begin
                ref_mem[12'h300 + 12'(4 * w + k)] = val[8*k +: 8];
            end
        end

        e = idle();
        for (int i = 0; i < 400; i++) begin
            int          kind;
            int          sz;
            int          off;
            logic [31:0] r;
            logic [11:0] a;
            bit          fault;

            v = idle();
            v.stall = (i > 0) && ($urandom_range(0, 4) == 0);
            v.valid = $urandom_range(0, 9) != 0;
            kind    = $urandom_range(0, 3);
            v.f3    = 3'($urandom_range(0, 7));
            off     = $urandom_range(0, 63);
            r       = $urandom();
            v.addr  = {r[31:12], 12'(12'h300 + off)};
            v.sdata = $urandom();
            v.pc4   = $urandom();
            v.rd    = 5'($urandom_range(0, 31));
            v.rw    = $urandom_range(0, 1) == 1;
            v.mr    = kind == 0;
            v.mw    = kind == 1;
            v.sel   = (kind == 0) ? WB_MEM : (kind == 1) ? WB_NONE : (kind == 2) ? WB_ALU : WB_PC4;

            if (!v.stall) begin
                a     = v.addr[11:0];
                sz    = 1 << v.f3[1:0];
                fault = v.valid && ((v.mr && (v.f3[1:0] == 2'b11 || (a % sz) != 0)) ||
                                    (v.mw && (v.f3 > 3'd2 || (a % sz) != 0)));
                e.e_valid = v.valid;
                e.e_rw    = v.valid && v.rw && !fault;
                e.e_fault = fault;
                e.e_rd    = v.rd;
                e.chk     = v.valid;
                case (v.sel)
                    WB_MEM:  e.e_data = fault ? 32'h0 : model_load(a, v.f3);
                    WB_ALU:  e.e_data = v.addr;
                    WB_PC4:  e.e_data = v.pc4;
                    default: e.e_data = 32'h0;
                endcase
                if (v.valid && v.mw && !fault) begin
                    for (int k = 0; k < sz; k++) begin
                        ref_mem[12'(a + k)] = v.sdata[8*k +: 8];
                    end
                end
            end
            v = with_exp(v, e);
            drive(v);
            tick();
            check_wb($sformatf("rnd%0d", i), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
